poliriscv_imem_loader: RTL and testbench
========================================

Name: poliriscv_imem_loader

Overview:
Program loader that writes the single-cycle core's instruction memory from a byte stream, replacing the fixed IFILE preload when a program is supplied at run time. It holds the core in reset while loading, checks length and checksum, then releases the core. It sits between a host byte source (UART receiver or bench) and the instruction-memory write port of poliriscv_sc.

Parameters:
instructions, 256, instruction-memory depth in 32-bit words; AW = $clog2(instructions)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR)
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  byte-stream ready; a transfer occurs on a rising edge with in_valid && in_ready
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
imem_waddr  output  AW  word address of the write
imem_wdata  output  32  word written
core_rst  output  1  reset to poliriscv_sc; high except in DONE
done  output  1  load completed and verified (level)
error  output  1  load rejected (level)
err_code  output  2  0 none, 1 bad length, 2 bad checksum

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word little-endian, byte 0 = bits 7:0), then one checksum byte = sum of all data bytes mod 256. Length bytes are excluded from the sum.
- Reset (async, takes effect immediately): state IDLE, core_rst=1, in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, done=0, error=0, err_code=0, word counter, byte index and checksum accumulator cleared.
- in_ready is a combinational decode of the state: 1 in LEN0, LEN1, DATA, CSUM; 0 otherwise. No back-pressure inside a frame: every state that accepts a byte accepts one per cycle.
- States:
  - IDLE: wait for start, then go to LEN0 and clear the counters, the accumulator, done, error and err_code. core_rst stays 1.
  - LEN0: on a transfer, latch the low byte and go to LEN1.
  - LEN1: on a transfer, form N. If N==0 or N>instructions, go to ERR with err_code=1. Otherwise go to DATA.
  - DATA: on each transfer, place the byte at lane byte_idx, add it to the accumulator, and increment byte_idx mod 4.
    - When the 4th byte of a word is accepted: on the next rising edge imem_we=1 for exactly one cycle, imem_waddr = word index (0 for the first word), imem_wdata = the assembled word.
    - Write latency is 1 cycle after the last byte's transfer edge. The next byte may be accepted in the same cycle as the write pulse.
    - After word N-1's 4th byte, go to CSUM.
  - CSUM: on a transfer, if the byte equals the accumulator go to DONE. Otherwise go to ERR with err_code=2.
  - DONE: done=1, core_rst=0 (registered, deasserts on the edge entering DONE). The core starts fetching from PC 0 the next cycle.
  - ERR: error=1, core_rst=1. Words already written stay in memory; the core is not released.
- start in DONE or ERR: go to LEN0, core_rst=1 on that same edge, and done, error and err_code clear. start in LEN0, LEN1, DATA or CSUM is ignored.
- Gaps (in_valid low) are allowed anywhere. State holds and there is no timeout.
- in_data is ignored when in_valid is low.
- imem_waddr and imem_wdata hold their last values when imem_we=0.
- An async reset mid-load aborts immediately. A partially assembled word is never written, and core_rst stays 1.
- N = instructions is legal and the last write goes to address instructions-1. The word counter must not wrap before the state reaches CSUM.

Test Plan:
- Nominal load: start, then bytes 02 00 93 00 A0 00 13 01 50 00 97 with in_valid held high. Required response:
  - imem_we pulses at addr 0 with data 00A00093, and at addr 1 with data 00500113.
  - done=1, err_code=0, core_rst falls on the edge after the 97 byte.
  - Afterwards, poliriscv_sc registers x1=0000000A and x2=00000005.
- Bad length: frames 00 00 and 01 01 (N=257 with instructions=256) -> ERR, error=1, err_code=1, no imem_we pulse, core_rst stays 1.
- Bad checksum: the nominal frame with a final byte of 98 -> both words written, then error=1, err_code=2, core_rst=1.
- Stream gaps: the nominal frame with in_valid low for 3 cycles between every byte -> identical writes (addr, data, order) and the same final state.
- Reset mid-load: assert rst after the 6th data byte -> all outputs at reset values immediately (before the next clock), only one imem_we pulse seen, state IDLE.
- Reload: from DONE, start, then a 1-word frame 01 00 B3 02 11 00 C6 -> core_rst rises on the start edge, one write of addr 0 = 001102B3, then done=1.

Source files
------------

// File: rtl/poliriscv_imem_loader.sv
// Streams a length-prefixed, checksummed program into instruction memory while
// holding the core in reset, then releases the core once the frame verifies.
module poliriscv_imem_loader #(
  parameter int unsigned instructions = 256,
  localparam int unsigned AW = $clog2(instructions)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [AW-1:0] n_last_q, n_last_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    acc_q, acc_d;
  logic [23:0]   buf_q, buf_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          xfer;
  logic [15:0]   n_len;
  logic [15:0]   n_m1;

  assign in_ready   = (state_q == StLen0) || (state_q == StLen1) ||
                      (state_q == StData) || (state_q == StCsum);
  assign xfer       = in_valid && in_ready;
  assign n_len      = {in_data, len_lo_q};
  assign n_m1       = n_len - 16'd1;

  // Status levels decode the registered state, so core_rst falls on the edge entering DONE.
  assign done       = (state_q == StDone);
  assign error      = (state_q == StErr);
  assign core_rst   = (state_q != StDone);
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign err_code   = err_code_q;

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    n_last_d   = n_last_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLen0;
          word_cnt_d = '0;
          byte_idx_d = '0;
          acc_d      = '0;
          err_code_d = 2'd0;
        end
      end
      StLen0: begin
        if (xfer) begin
          len_lo_d = in_data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (xfer) begin
          if (n_len == 16'd0 || 32'(n_len) > instructions) begin
            state_d    = StErr;
            err_code_d = 2'd1;
          end else begin
            n_last_d = n_m1[AW-1:0];
            state_d  = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          acc_d      = acc_q + in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: buf_d[7:0]   = in_data;
            2'd1: buf_d[15:8]  = in_data;
            2'd2: buf_d[23:16] = in_data;
            2'd3: begin
              we_d       = 1'b1;
              waddr_d    = word_cnt_q;
              wdata_d    = {in_data, buf_q};
              word_cnt_d = word_cnt_q + 1'b1;
              // Leave before the counter can wrap when N equals the memory depth.
              if (word_cnt_q == n_last_q) state_d = StCsum;
            end
          endcase
        end
      end
      StCsum: begin
        if (xfer) begin
          if (in_data == acc_q) begin
            state_d = StDone;
          end else begin
            state_d    = StErr;
            err_code_d = 2'd2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      len_lo_q   <= '0;
      n_last_q   <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      acc_q      <= '0;
      buf_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      n_last_q   <= n_last_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      buf_q      <= buf_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_poliriscv_imem_loader.sv
// Randomized frame stimulus checked every cycle against a byte-count model of the
// frame format, plus literal checks of the directed frames.
module tb_poliriscv_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, core_rst, done, error;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [1:0]  err_code;

  poliriscv_imem_loader #(.instructions(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 loading, 2 done, 3 rejected; everything else follows from
  // how many frame bytes have been accepted so far.
  int          m_phase, m_k, m_n, m_sum;
  logic [7:0]  m_b[$];
  logic        m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_code;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_k = 0; m_n = 0; m_we = 0; m_addr = 0; m_data = 0; m_code = 0;
      m_b.delete();
    end else begin
      m_we = 1'b0;
      if (m_phase == 1 && in_valid) begin
        m_b.push_back(in_data);
        m_k++;
        if (m_k == 1) begin
        end else if (m_k == 2) begin
          m_n = {m_b[1], m_b[0]};
          if (m_n == 0 || m_n > 256) begin m_phase = 3; m_code = 2'd1; end
        end else if (m_k <= 2 + 4 * m_n) begin
          if ((m_k - 2) % 4 == 0) begin
            m_we   = 1'b1;
            m_addr = 8'((m_k - 2) / 4 - 1);
            m_data = {m_b[m_k-1], m_b[m_k-2], m_b[m_k-3], m_b[m_k-4]};
          end
        end else begin
          m_sum = 0;
          for (int i = 2; i < 2 + 4 * m_n; i++) m_sum += m_b[i];
          if (m_sum % 256 == int'(m_b[m_k-1])) m_phase = 2;
          else begin m_phase = 3; m_code = 2'd2; end
        end
      end else if (start && m_phase != 1) begin
        m_phase = 1; m_k = 0; m_code = 2'd0;
        m_b.delete();
      end
    end
  end

  logic [7:0]  wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, m_phase == 1);
      chk("imem_we", imem_we, m_we);
      chk("imem_waddr", imem_waddr, m_addr);
      chk("imem_wdata", imem_wdata, m_data);
      chk("done", done, m_phase == 2);
      chk("error", error, m_phase == 3);
      chk("err_code", err_code, m_code);
      chk("core_rst", core_rst, m_phase != 2);
      if (imem_we) begin
        wa.push_back(imem_waddr);
        wd.push_back(imem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_list(input logic [7:0] bl[$], input int gap);
    foreach (bl[i]) send(bl[i], gap);
  endtask

  // Random frame of n words; an illegal n sends only the length bytes.
  task automatic send_frame(input int n, input bit bad_cs, input int maxgap, input bit poke);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    send(8'(n), $urandom_range(0, maxgap));
    send(8'(n >> 8), $urandom_range(0, maxgap));
    if (n >= 1 && n <= 256) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        s = s + b;
        send(b, $urandom_range(0, maxgap));
        if (poke && i == 1) pulse_start();
      end
      send(bad_cs ? (s ^ 8'(1 + $urandom_range(0, 254))) : s, 0);
    end
  endtask

  logic [7:0] nominal[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                             8'h13, 8'h01, 8'h50, 8'h00, 8'h97};
  logic [7:0] bad_cs[$]  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
                             8'h13, 8'h01, 8'h50, 8'h00, 8'h98};
  logic [7:0] reload[$]  = '{8'h01, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h00, 8'hC6};

  task automatic check_nominal(input string tag);
    chk({tag, "_nwr"}, wa.size(), 2);
    chk({tag, "_a0"}, wa[0], 8'd0);
    chk({tag, "_d0"}, wd[0], 32'h00A00093);
    chk({tag, "_a1"}, wa[1], 8'd1);
    chk({tag, "_d1"}, wd[1], 32'h00500113);
  endtask

  initial begin
    int n, kind;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_done_err", {done, error, err_code}, 4'b0000);
    rst = 1'b0;
    tick();

    // Nominal load
    wa.delete(); wd.delete();
    pulse_start();
    send_list(nominal, 0);
    check_nominal("nom");
    chk("nom_done", {done, error, err_code, core_rst}, 5'b10000);

    // Reload from DONE
    wa.delete(); wd.delete();
    pulse_start();
    chk("reload_core_rst", core_rst, 1'b1);
    send_list(reload, 0);
    chk("reload_nwr", wa.size(), 1);
    chk("reload_d0", wd[0], 32'h001102B3);
    chk("reload_done", {done, core_rst}, 2'b10);

    // Bad lengths
    wa.delete(); wd.delete();
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
    chk("len0_err", {error, err_code, core_rst}, 4'b1011);
    pulse_start();
    send(8'h01, 0); send(8'h01, 0);
    chk("len257_err", {error, err_code, core_rst}, 4'b1011);
    chk("badlen_nwr", wa.size(), 0);

    // Bad checksum
    wa.delete(); wd.delete();
    pulse_start();
    send_list(bad_cs, 0);
    check_nominal("bcs");
    chk("bcs_err", {done, error, err_code, core_rst}, 5'b01101);

    // Gaps of three cycles, with an ignored start mid-frame
    wa.delete(); wd.delete();
    pulse_start();
    for (int i = 0; i < nominal.size(); i++) begin
      send(nominal[i], 3);
      if (i == 4) pulse_start();
    end
    check_nominal("gap");
    chk("gap_done", {done, error, err_code, core_rst}, 5'b10000);

    // Reset mid-load after the 6th data byte
    wa.delete(); wd.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send(nominal[i], 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_core_rst", core_rst, 1'b1);
    chk("mid_in_ready", in_ready, 1'b0);
    chk("mid_we", imem_we, 1'b0);
    chk("mid_waddr", imem_waddr, 8'd0);
    chk("mid_wdata", imem_wdata, 32'd0);
    chk("mid_status", {done, error, err_code}, 4'b0000);
    chk("mid_nwr", wa.size(), 1);
    #3;
    rst = 1'b0;
    tick();
    tick();
    chk("mid_idle_ready", in_ready, 1'b0);

    // Full-depth frame
    wa.delete(); wd.delete();
    pulse_start();
    send_frame(256, 1'b0, 0, 1'b0);
    chk("full_nwr", wa.size(), 256);
    chk("full_last_addr", wa[255], 8'd255);
    chk("full_done", {done, core_rst}, 2'b10);

    // Random frames
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) n = ($urandom_range(0, 1) == 0) ? 0 : 257 + $urandom_range(0, 5000);
      else n = $urandom_range(1, 5);
      pulse_start();
      send_frame(n, kind == 1, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      if (kind == 0) chk("rnd_len_err", {error, err_code}, 3'b101);
      else if (kind == 1) chk("rnd_cs_err", {error, err_code}, 3'b110);
      else chk("rnd_done", {done, core_rst}, 2'b10);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
